button_conditioner: RTL

- Front-end stage directly upstream of the menu state machine.
- Takes raw, bouncing, asynchronous push-button inputs and synchronizes and debounces each one.
- Emits a clean debounced level per button, plus a single-cycle press pulse per button.
- These pulses drive the menu's in_mode, scale_val_in and hex_BCD_in inputs, so each physical press advances the menu exactly once.

---
 rtl/button_conditioner.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: two-flop synchronizer plus an independent debounce FSM per button channel.
// Outputs a clean level and a one-cycle press pulse per channel; define BTN_AUTO_REPEAT_EN for auto-repeat.
module button_conditioner #(
    parameter int               N_BTN                = 3,
    parameter int               STABLE_CYCLES        = 5_000_000,
    parameter int               REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int               REPEAT_PERIOD_CYCLES = 20_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK          = 'b010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [N_BTN-1:0]         s1_q, s2_q;
    logic [N_BTN-1:0]         level_q, level_d;
    logic [N_BTN-1:0]         pulse_q, pulse_d;
    logic [N_BTN-1:0][CW-1:0] cnt_q, cnt_d;
    state_t                   state_q [N_BTN];
    state_t                   state_d [N_BTN];

`ifdef BTN_AUTO_REPEAT_EN
    localparam int            RMAX     = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                         REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int            RW       = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);
    localparam logic [RW-1:0] RPT_ONE  = RW'(1);

    logic [N_BTN-1:0][RW-1:0] rpt_q, rpt_d;
    // per_q marks that the initial delay has elapsed and the period interval now applies
    logic [N_BTN-1:0]         per_q, per_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            pulse_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_q <= '0;
            per_q <= '0;
        end else begin
            rpt_q <= rpt_d;
            per_q <= per_d;
        end
    end
`endif

    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        cnt_d   = cnt_q;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_d   = rpt_q;
        per_d   = per_q;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (s2_q[i]) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d[i] = PRESSED;
                            level_d[i] = 1'b1;
                            pulse_d[i] = 1'b1;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = ARM_PRESS;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                ARM_PRESS: begin
                    if (!s2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRESSED;
                        level_d[i] = 1'b1;
                        pulse_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!s2_q[i]) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d[i] = IDLE;
                            level_d[i] = 1'b0;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = ARM_RELEASE;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                ARM_RELEASE: begin
                    if (s2_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                        level_d[i] = 1'b0;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
`ifdef BTN_AUTO_REPEAT_EN
            // Counts only while settled in PRESSED, so a release bounce freezes it
            if (REPEAT_MASK[i]) begin
                if (state_q[i] == PRESSED && state_d[i] == PRESSED) begin
                    if (rpt_q[i] == (per_q[i] ? PER_LAST : DLY_LAST)) begin
                        pulse_d[i] = 1'b1;
                        rpt_d[i]   = '0;
                        per_d[i]   = 1'b1;
                    end else begin
                        rpt_d[i]   = rpt_q[i] + RPT_ONE;
                    end
                end else if (state_d[i] == IDLE) begin
                    rpt_d[i] = '0;
                    per_d[i] = 1'b0;
                end
            end else begin
                rpt_d[i] = '0;
                per_d[i] = 1'b0;
            end
`endif
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule
